// File: rtl/switch_out_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : switch_out_arbiter
// Description : Output-side arbiter for a 4x4 switch. Every output port runs
//               its own IDLE/BUSY machine and grants one input at a time,
//               using a rotating (round-robin) search pointer. An input whose
//               destination byte is illegal is flagged with a registered drop
//               pulse and is never granted.
//
// Ports       : clk        - single clock, rising edge
//               reset      - asynchronous, active-high
//               valid_in   - [3:0]  per-input request, held until in_ack/drop
//               addr_in    - [31:0] destination byte per input (port i: [8i+7:8i])
//               rcv_rdy    - [3:0]  per-output receiver ready
//               data_rd    - [3:0]  per-output transfer-complete acknowledge
//               grant_sel  - [7:0]  granted input index for output j in [2j+1:2j]
//               valid_out  - [3:0]  output j owns a granted transfer
//               in_ack     - [3:0]  one-cycle pulse, request of input i accepted
//               drop       - [3:0]  one-cycle pulse, input i has illegal destination
//               timeout    - [3:0]  one-cycle pulse, output j force-released
//
// Build option: define ARB_TIMEOUT_EN to add per-output watchdog counters that
//               force a BUSY output back to IDLE after TIMEOUT_CYCLES cycles
//               without data_rd. Without it timeout is tied low.
//
// Revision    : 1.0 - initial release
// ============================================================================
module switch_out_arbiter #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  valid_in,
    input  logic [31:0] addr_in,
    input  logic [3:0]  rcv_rdy,
    input  logic [3:0]  data_rd,
    output logic [7:0]  grant_sel,
    output logic [3:0]  valid_out,
    output logic [3:0]  in_ack,
    output logic [3:0]  drop,
    output logic [3:0]  timeout
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t     r_state [4];
    logic [1:0] r_ptr   [4];
    logic [1:0] r_sel   [4];
    logic [3:0] r_valid_out;
    logic [3:0] r_in_ack;
    logic [3:0] r_drop;

    logic [3:0] w_legal;
    logic [1:0] w_dest    [4];
    logic [3:0] w_busy_in;
    logic [3:0] w_req     [4];   // w_req[j][i]: input i requests output j
    logic [3:0] w_win_found;
    logic [1:0] w_win_idx [4];
    logic [3:0] w_grant;
    logic [3:0] w_release;
    logic [3:0] w_expire;
    logic [3:0] w_ack_next;

    // Zero is not a meaningful watchdog length; this block only exists so the
    // parameter is referenced in every build.
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout_cycles
    end

    // ------------------------------------------------------------------------
    // Request decode and round-robin winner search
    // ------------------------------------------------------------------------
    always_comb begin
        logic [1:0] w_cand;
        w_busy_in  = '0;
        w_win_found = '0;
        w_grant    = '0;
        w_ack_next = '0;
        w_cand     = 2'd0;
        for (int i = 0; i < 4; i++) begin
            w_legal[i] = (addr_in[8*i+2 +: 6] == 6'd0);
            w_dest[i]  = addr_in[8*i +: 2];
        end
        // An input already owning some output may not be granted again.
        for (int j = 0; j < 4; j++) begin
            if (r_state[j] == S_BUSY) begin
                w_busy_in[r_sel[j]] = 1'b1;
            end
        end
        for (int j = 0; j < 4; j++) begin
            for (int i = 0; i < 4; i++) begin
                w_req[j][i] = valid_in[i] & w_legal[i] &
                              (w_dest[i] == 2'(j)) & ~w_busy_in[i];
            end
            // Scan from the farthest candidate back to ptr so the candidate
            // nearest to ptr is the one left standing.
            w_win_idx[j] = r_ptr[j];
            for (int k = 3; k >= 0; k--) begin
                w_cand = r_ptr[j] + 2'(k);
                if (w_req[j][w_cand]) begin
                    w_win_found[j] = 1'b1;
                    w_win_idx[j]   = w_cand;
                end
            end
            w_grant[j] = (r_state[j] == S_IDLE) & rcv_rdy[j] & w_win_found[j];
            // Each input targets a single destination, so at most one output
            // can grant a given input in any cycle.
            if (w_grant[j]) begin
                w_ack_next[w_win_idx[j]] = 1'b1;
            end
            w_release[j] = (r_state[j] == S_BUSY) & (data_rd[j] | w_expire[j]);
        end
    end

    // ------------------------------------------------------------------------
    // Per-output FSMs and registered pulse outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int j = 0; j < 4; j++) begin
                r_state[j] <= S_IDLE;
                r_ptr[j]   <= 2'd0;
                r_sel[j]   <= 2'd0;
            end
            r_valid_out <= '0;
            r_in_ack    <= '0;
            r_drop      <= '0;
        end else begin
            r_in_ack <= w_ack_next;
            r_drop   <= valid_in & ~w_legal;
            for (int j = 0; j < 4; j++) begin
                if (w_grant[j]) begin
                    r_state[j]     <= S_BUSY;
                    r_sel[j]       <= w_win_idx[j];
                    r_valid_out[j] <= 1'b1;
                end else if (w_release[j]) begin
                    // grant_sel is kept; only the pointer moves past the
                    // input just served (2-bit wrap).
                    r_state[j]     <= S_IDLE;
                    r_valid_out[j] <= 1'b0;
                    r_ptr[j]       <= r_sel[j] + 2'd1;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Optional BUSY watchdog
    // ------------------------------------------------------------------------
`ifdef ARB_TIMEOUT_EN
    localparam int c_CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);

    logic [c_CNT_W-1:0] r_cnt [4];
    logic [3:0]         r_timeout;

    // The count compares against LAST so the release lands at the end of the
    // TIMEOUT_CYCLES-th BUSY cycle; data_rd in that cycle wins.
    always_comb begin
        for (int j = 0; j < 4; j++) begin
            w_expire[j] = (r_state[j] == S_BUSY) & ~data_rd[j] &
                          (r_cnt[j] == c_CNT_LAST);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int j = 0; j < 4; j++) begin
                r_cnt[j] <= '0;
            end
            r_timeout <= '0;
        end else begin
            r_timeout <= w_expire;
            for (int j = 0; j < 4; j++) begin
                if (w_grant[j]) begin
                    r_cnt[j] <= '0;
                end else if ((r_state[j] == S_BUSY) && !data_rd[j] && !w_expire[j]) begin
                    r_cnt[j] <= r_cnt[j] + c_CNT_W'(1);
                end
            end
        end
    end

    assign timeout = r_timeout;
`else
    assign w_expire = '0;
    assign timeout  = '0;
`endif

    // ------------------------------------------------------------------------
    // Output mapping
    // ------------------------------------------------------------------------
    for (genvar j = 0; j < 4; j++) begin : g_grant_sel
        assign grant_sel[2*j +: 2] = r_sel[j];
    end

    assign valid_out = r_valid_out;
    assign in_ack    = r_in_ack;
    assign drop      = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_switch_out_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_switch_out_arbiter
// Description : Directed table-driven bench for switch_out_arbiter. Each
//               table row is applied for one clock and the registered outputs
//               are compared one time unit after the following rising edge.
//               Hand-written sequences cover async reset mid-transfer and the
//               BUSY watchdog (behaviour depends on ARB_TIMEOUT_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_switch_out_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  valid_in;
    logic [31:0] addr_in;
    logic [3:0]  rcv_rdy;
    logic [3:0]  data_rd;
    logic [7:0]  grant_sel;
    logic [3:0]  valid_out;
    logic [3:0]  in_ack;
    logic [3:0]  drop;
    logic [3:0]  timeout;

    int n_vec = 0;
    int n_err = 0;

    switch_out_arbiter #(.TIMEOUT_CYCLES(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .valid_in  (valid_in),
        .addr_in   (addr_in),
        .rcv_rdy   (rcv_rdy),
        .data_rd   (data_rd),
        .grant_sel (grant_sel),
        .valid_out (valid_out),
        .in_ack    (in_ack),
        .drop      (drop),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  vin;
        logic [31:0] addr;
        logic [3:0]  rdy;
        logic [3:0]  drd;
        logic [3:0]  vo;
        logic [7:0]  gs;
        logic [3:0]  ack;
        logic [3:0]  drp;
    } vec_t;

    localparam int NV = 27;
    vec_t tbl [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] v, input logic [31:0] a,
                         input logic [3:0] r, input logic [3:0] d);
        valid_in = v;
        addr_in  = a;
        rcv_rdy  = r;
        data_rd  = d;
    endtask

    initial begin
        //            vin      addr          rdy      drd      vo       gs     ack      drp
        // single grant to output 2 and release
        tbl[0]  = '{4'b0001, 32'h0000_0002, 4'b0100, 4'b0000, 4'b0100, 8'h00, 4'b0001, 4'b0000};
        tbl[1]  = '{4'b0000, 32'h0000_0002, 4'b0000, 4'b0000, 4'b0100, 8'h00, 4'b0000, 4'b0000};
        tbl[2]  = '{4'b0000, 32'h0000_0002, 4'b0000, 4'b0100, 4'b0000, 8'h00, 4'b0000, 4'b0000};
        // all four inputs contend for output 1: order 0,1,2,3,0
        tbl[3]  = '{4'b1111, 32'h0101_0101, 4'b0010, 4'b0000, 4'b0010, 8'h00, 4'b0001, 4'b0000};
        tbl[4]  = '{4'b1110, 32'h0101_0101, 4'b0010, 4'b0010, 4'b0000, 8'h00, 4'b0000, 4'b0000};
        tbl[5]  = '{4'b1110, 32'h0101_0101, 4'b0010, 4'b0000, 4'b0010, 8'h04, 4'b0010, 4'b0000};
        tbl[6]  = '{4'b1100, 32'h0101_0101, 4'b0010, 4'b0010, 4'b0000, 8'h04, 4'b0000, 4'b0000};
        tbl[7]  = '{4'b1100, 32'h0101_0101, 4'b0010, 4'b0000, 4'b0010, 8'h08, 4'b0100, 4'b0000};
        tbl[8]  = '{4'b1000, 32'h0101_0101, 4'b0010, 4'b0010, 4'b0000, 8'h08, 4'b0000, 4'b0000};
        tbl[9]  = '{4'b1000, 32'h0101_0101, 4'b0010, 4'b0000, 4'b0010, 8'h0C, 4'b1000, 4'b0000};
        tbl[10] = '{4'b0001, 32'h0101_0101, 4'b0010, 4'b0010, 4'b0000, 8'h0C, 4'b0000, 4'b0000};
        tbl[11] = '{4'b0001, 32'h0101_0101, 4'b0010, 4'b0000, 4'b0010, 8'h00, 4'b0001, 4'b0000};
        tbl[12] = '{4'b0000, 32'h0101_0101, 4'b0010, 4'b0010, 4'b0000, 8'h00, 4'b0000, 4'b0000};
        // data_rd while idle has no effect
        tbl[13] = '{4'b0000, 32'h0000_0000, 4'b0000, 4'b1111, 4'b0000, 8'h00, 4'b0000, 4'b0000};
        // illegal destination on input 2
        tbl[14] = '{4'b0100, 32'h0045_0000, 4'b1111, 4'b0000, 4'b0000, 8'h00, 4'b0000, 4'b0100};
        tbl[15] = '{4'b0100, 32'h0045_0000, 4'b1111, 4'b0000, 4'b0000, 8'h00, 4'b0000, 4'b0100};
        tbl[16] = '{4'b0000, 32'h0045_0000, 4'b1111, 4'b0000, 4'b0000, 8'h00, 4'b0000, 4'b0000};
        // simultaneous grants: input 0 -> out 2, input 3 -> out 0
        tbl[17] = '{4'b1001, 32'h0000_0002, 4'b1111, 4'b0000, 4'b0101, 8'h03, 4'b1001, 4'b0000};
        tbl[18] = '{4'b0000, 32'h0000_0002, 4'b0000, 4'b0101, 4'b0000, 8'h03, 4'b0000, 4'b0000};
        // ptr[0] wrapped 3->0: input 0 wins over 1
        tbl[19] = '{4'b0011, 32'h0000_0000, 4'b0001, 4'b0000, 4'b0001, 8'h00, 4'b0001, 4'b0000};
        // release cycle: input 1 still requesting, no grant
        tbl[20] = '{4'b0010, 32'h0000_0000, 4'b0001, 4'b0001, 4'b0000, 8'h00, 4'b0000, 4'b0000};
        // input 1 granted on out 1, then retargets out 0 while busy: excluded
        tbl[21] = '{4'b0010, 32'h0000_0100, 4'b0011, 4'b0000, 4'b0010, 8'h04, 4'b0010, 4'b0000};
        tbl[22] = '{4'b0010, 32'h0000_0000, 4'b0011, 4'b0000, 4'b0010, 8'h04, 4'b0000, 4'b0000};
        tbl[23] = '{4'b0000, 32'h0000_0000, 4'b0011, 4'b0010, 4'b0000, 8'h04, 4'b0000, 4'b0000};
        // receiver not ready blocks the grant
        tbl[24] = '{4'b0001, 32'h0000_0000, 4'b0000, 4'b0000, 4'b0000, 8'h04, 4'b0000, 4'b0000};
        tbl[25] = '{4'b0001, 32'h0000_0000, 4'b0001, 4'b0000, 4'b0001, 8'h04, 4'b0001, 4'b0000};
        // release out 0 (ptr0 -> 1) while out 3 grants input 1
        tbl[26] = '{4'b0010, 32'h0000_0300, 4'b1000, 4'b0001, 4'b1000, 8'h44, 4'b0010, 4'b0000};

        reset = 1'b1;
        drive(4'b0000, 32'h0, 4'b0000, 4'b0000);
        tick();
        tick();
        check("reset valid_out", {28'd0, valid_out}, 32'd0);
        check("reset grant_sel", {24'd0, grant_sel}, 32'd0);
        check("reset pulses", {20'd0, in_ack, drop, timeout}, 32'd0);
        reset = 1'b0;

        for (int k = 0; k < NV; k++) begin
            drive(tbl[k].vin, tbl[k].addr, tbl[k].rdy, tbl[k].drd);
            tick();
            check($sformatf("vec%0d valid_out", k), {28'd0, valid_out}, {28'd0, tbl[k].vo});
            check($sformatf("vec%0d grant_sel", k), {24'd0, grant_sel}, {24'd0, tbl[k].gs});
            check($sformatf("vec%0d in_ack", k),    {28'd0, in_ack},    {28'd0, tbl[k].ack});
            check($sformatf("vec%0d drop", k),      {28'd0, drop},      {28'd0, tbl[k].drp});
            check($sformatf("vec%0d timeout", k),   {28'd0, timeout},   32'd0);
        end

        // Async reset while output 3 is BUSY (in_ack for input 1 currently high)
        drive(4'b0000, 32'h0, 4'b0000, 4'b0000);
        #3;
        reset = 1'b1;
        #1;
        check("async reset valid_out", {28'd0, valid_out}, 32'd0);
        check("async reset grant_sel", {24'd0, grant_sel}, 32'd0);
        check("async reset in_ack", {28'd0, in_ack, timeout}, 32'd0);
        tick();
        reset = 1'b0;
        // ptr[0] was 1 before reset; after reset input 0 must win again
        drive(4'b0011, 32'h0000_0000, 4'b0001, 4'b0000);
        tick();
        check("post-reset valid_out", {28'd0, valid_out}, 32'h1);
        check("post-reset grant_sel", {24'd0, grant_sel}, 32'h00);
        check("post-reset in_ack", {28'd0, in_ack}, 32'h1);
        drive(4'b0000, 32'h0, 4'b0000, 4'b0001);
        tick();
        check("post-reset release", {28'd0, valid_out}, 32'h0);

        // Watchdog: grant output 2 to input 0 and withhold data_rd
        drive(4'b0001, 32'h0000_0002, 4'b0100, 4'b0000);
        tick();
        check("wd grant", {28'd0, valid_out}, 32'h4);
        drive(4'b0000, 32'h0, 4'b0000, 4'b0000);
`ifdef ARB_TIMEOUT_EN
        for (int k = 1; k < 16; k++) begin
            tick();
            check($sformatf("wd busy %0d", k), {28'd0, valid_out, timeout}, 32'h40);
        end
        tick();
        check("wd expire", {28'd0, valid_out, timeout}, 32'h04);
        tick();
        check("wd pulse end", {28'd0, valid_out, timeout}, 32'h00);
        // data_rd in the 16th BUSY cycle wins over the watchdog
        drive(4'b0001, 32'h0000_0002, 4'b0100, 4'b0000);
        tick();
        check("wd regrant", {28'd0, valid_out}, 32'h4);
        drive(4'b0000, 32'h0, 4'b0000, 4'b0000);
        for (int k = 1; k < 16; k++) begin
            tick();
            check($sformatf("wd2 busy %0d", k), {28'd0, valid_out, timeout}, 32'h40);
        end
        data_rd = 4'b0100;
        tick();
        check("wd data_rd wins", {28'd0, valid_out, timeout}, 32'h00);
        data_rd = 4'b0000;
        tick();
        check("wd no late pulse", {28'd0, timeout}, 32'h0);
`else
        for (int k = 1; k <= 20; k++) begin
            tick();
            check($sformatf("hold busy %0d", k), {28'd0, valid_out, timeout}, 32'h40);
        end
        data_rd = 4'b0100;
        tick();
        check("hold release", {28'd0, valid_out, timeout}, 32'h00);
        data_rd = 4'b0000;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/switch_out_arbiter.md
SWITCH_OUT_ARBITER -- requirements
Module: switch_out_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16: BUSY cycles without data_rd before forced release (used only with ARB_TIMEOUT_EN).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port valid_in  input  4  per-input-port request; bit i held high until in_ack[i] or drop[i].
REQ-005 SHALL have port addr_in  input  32  destination byte per input port; port i uses bits [8i+7:8i].
REQ-006 SHALL have port rcv_rdy  input  4  per-output-port receiver ready.
REQ-007 SHALL have port data_rd  input  4  per-output-port transfer-complete acknowledge.
REQ-008 SHALL have port grant_sel  output  8  selected input index for output j in bits [2j+1:2j].
REQ-009 SHALL have port valid_out  output  4  output j owns a granted transfer.
REQ-010 SHALL have port in_ack  output  4  one-cycle pulse: request of input i accepted.
REQ-011 SHALL have port drop  output  4  one-cycle pulse per cycle input i presents an illegal destination.
REQ-012 SHALL have port timeout  output  4  one-cycle pulse on forced release of output j (constant 0 without ARB_TIMEOUT_EN).

Function
REQ-013 Address byte legal only if bits [7:2] are 0; destination j = bits [1:0].
REQ-014 req[i][j] = valid_in[i] AND legal AND destination==j AND input i not currently granted anywhere.
REQ-015 Each output j SHALL run an independent FSM, states IDLE and BUSY.
REQ-016 IDLE -> BUSY when rcv_rdy[j]=1 and any req[*][j]=1; winner = first requester searching ptr[j], ptr[j]+1, ... mod 4.
REQ-017 On IDLE->BUSY edge: grant_sel[j]<=winner, valid_out[j]<=1, in_ack[winner] pulses for exactly the following cycle.
REQ-018 BUSY: grant_sel[j] and valid_out[j] held stable; rcv_rdy[j] and new requests ignored.
REQ-019 BUSY -> IDLE when data_rd[j]=1: valid_out[j]<=0, ptr[j]<=grant_sel[j]+1 mod 4 (2-bit wrap, 3->0).
REQ-020 No grant in the release cycle; minimum one IDLE cycle between consecutive grants on the same output.
REQ-021 data_rd[j] while IDLE SHALL be ignored.
REQ-022 Simultaneous grants on different outputs in the same cycle SHALL be permitted; an input never receives two grants (REQ-014).
REQ-023 drop[i] registered: asserted the cycle after valid_in[i]=1 with illegal byte; never accompanies in_ack[i].
REQ-024 Latency: request at edge N with output IDLE and ready -> valid_out and in_ack high after edge N+1.

Reset
REQ-025 While reset=1: all FSMs IDLE, ptr[*]=0, grant_sel=0, valid_out=0, in_ack=0, drop=0, timeout=0, timeout counters 0.
REQ-026 Reset asserted mid-BUSY SHALL abort the transfer immediately without timeout or in_ack pulses.

Configuration
REQ-027 Macro ARB_TIMEOUT_EN defined: per-output counter clears on IDLE->BUSY, increments each BUSY cycle without data_rd; on reaching TIMEOUT_CYCLES output goes IDLE, timeout[j] pulses one cycle, ptr[j] advances as in REQ-019.
REQ-028 data_rd[j] on the same cycle the count is reached SHALL win: normal release, no timeout pulse.
REQ-029 Macro not defined: no counters instantiated, timeout tied 0, BUSY persists until data_rd.

Verification
REQ-030 valid_in=0001, addr byte0=0x02, rcv_rdy=0100 -> next cycle valid_out=0100, grant_sel[5:4]=0, in_ack=0001 one cycle.
REQ-031 Inputs 0-3 all target output 1, ptr=0, data_rd after each grant -> grant order 0,1,2,3,0; one IDLE cycle between grants.
REQ-032 Input 2 addr byte=0x45 -> drop=0100 each following cycle held; no valid_out change.
REQ-033 Inputs 0 and 3 target outputs 2 and 0 in same cycle, all rcv_rdy=1 -> valid_out=0101 same cycle, in_ack=1001.
REQ-034 ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, no data_rd -> release after 16 BUSY cycles, timeout[j] one pulse; data_rd on cycle 16 -> no pulse.
REQ-035 reset pulsed while output 3 BUSY -> valid_out=0, grant_sel=0 immediately; next grant starts search at input 0.
